// File: rtl/xmodem_rx_ctrl.sv
// XMODEM (checksum variant) receive controller.
// Parses SOH / blk / ~blk / 128 data / checksum packets, answers ACK/NAK,
// and writes a block to memory only after it has been verified.
// Optional build macro XMODEM_TIMEOUT_EN: idle timeout in WAIT_HDR..CSUM
// abandons the partial packet and sends a retry NAK after TIMEOUT_CYC cycles.
module xmodem_rx_ctrl #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_cnt
);

  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EOT = 8'h04;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_HDR, S_BLK, S_BLKN, S_DATA, S_CSUM,
    S_CHECK, S_COMMIT, S_SEND_ACK, S_SEND_NAK
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          blk_q, blk_d, blkn_q, blkn_d, csum_q, csum_d, sum_q, sum_d;
  logic [6:0]          idx_q, idx_d, cidx_q, cidx_d;
  logic [7:0]          exp_blk_q, exp_blk_d;
  logic                eot_q, eot_d, cnt_nak_q, cnt_nak_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                mem_we;
  logic [7:0]          mem_q [128];

`ifdef XMODEM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          in_rx;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_cnt  = err_cnt_q;

  // Block buffer; contents need no reset since every commit is preceded by a full fill.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= rx_data;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    blkn_d     = blkn_q;
    csum_d     = csum_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    cidx_d     = cidx_q;
    exp_blk_d  = exp_blk_q;
    eot_d      = eot_q;
    cnt_nak_d  = cnt_nak_q;
    tx_data_d  = tx_data_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_cnt_d  = err_cnt_q;
    mem_we     = 1'b0;

    if (wr_en_q) wr_addr_d = wr_addr_q + ADDR_W'(1);

    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_SEND_NAK;
        tx_data_d = NAK;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        err_cnt_d = '0;
        wr_addr_d = '0;
        exp_blk_d = 8'd1;
        eot_d     = 1'b0;
        cnt_nak_d = 1'b0;   // the solicitation NAK is not an error
      end
      S_WAIT_HDR: if (rx_valid) begin
        if (rx_data == SOH) begin
          state_d = S_BLK;
        end else if (rx_data == EOT) begin
          state_d   = S_SEND_ACK;
          tx_data_d = ACK;
          eot_d     = 1'b1;
        end
      end
      S_BLK: if (rx_valid) begin
        blk_d   = rx_data;
        state_d = S_BLKN;
      end
      S_BLKN: if (rx_valid) begin
        blkn_d  = rx_data;
        sum_d   = '0;
        idx_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: if (rx_valid) begin
        mem_we = 1'b1;
        sum_d  = sum_q + rx_data;
        idx_d  = idx_q + 7'd1;
        if (idx_q == 7'd127) state_d = S_CSUM;
      end
      S_CSUM: if (rx_valid) begin
        csum_d  = rx_data;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (blkn_q != ~blk_q || csum_q != sum_q) begin
          state_d   = S_SEND_NAK;
          tx_data_d = NAK;
          cnt_nak_d = 1'b1;
        end else if (blk_q == exp_blk_q - 8'd1) begin
          state_d   = S_SEND_ACK;
          tx_data_d = ACK;
        end else if (blk_q == exp_blk_q) begin
          state_d = S_COMMIT;
          cidx_d  = '0;
          wr_en_d = 1'b1;
        end else begin
          state_d   = S_SEND_NAK;
          tx_data_d = NAK;
          cnt_nak_d = 1'b1;
        end
      end
      S_COMMIT: begin
        if (cidx_q == 7'd127) begin
          state_d   = S_SEND_ACK;
          tx_data_d = ACK;
          exp_blk_d = exp_blk_q + 8'd1;
        end else begin
          cidx_d  = cidx_q + 7'd1;
          wr_en_d = 1'b1;
        end
      end
      S_SEND_ACK: if (tx_ready) begin
        if (eot_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          eot_d   = 1'b0;
        end else begin
          state_d = S_WAIT_HDR;
        end
      end
      S_SEND_NAK: if (tx_ready) begin
        state_d   = S_WAIT_HDR;
        cnt_nak_d = 1'b0;
        if (cnt_nak_q && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef XMODEM_TIMEOUT_EN
    // Receive states only leave on rx_valid, so a quiet cycle here means state_d == state_q.
    in_rx = state_q inside {S_WAIT_HDR, S_BLK, S_BLKN, S_DATA, S_CSUM};
    if (in_rx && !rx_valid && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d   = S_SEND_NAK;
      tx_data_d = NAK;
      cnt_nak_d = 1'b1;
    end
    if (!in_rx || rx_valid || state_d != state_q) tmo_d = '0;
    else                                           tmo_d = tmo_q + TW'(1);
`endif

    if (wr_en_d) wr_data_d = mem_q[cidx_d];
    tx_valid_d = (state_d == S_SEND_ACK) || (state_d == S_SEND_NAK);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      blk_q      <= '0;
      blkn_q     <= '0;
      csum_q     <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      cidx_q     <= '0;
      exp_blk_q  <= 8'd1;
      eot_q      <= 1'b0;
      cnt_nak_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      blkn_q     <= blkn_d;
      csum_q     <= csum_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      cidx_q     <= cidx_d;
      exp_blk_q  <= exp_blk_d;
      eot_q      <= eot_d;
      cnt_nak_q  <= cnt_nak_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

`ifdef XMODEM_TIMEOUT_EN
  // Idle-cycle counter for the retry timeout.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_xmodem_rx_ctrl.sv
// Directed bench for xmodem_rx_ctrl: packet vector table plus hand-written
// sequences for reset, EOT with back-pressure, restart and idle timeout.
module tb_xmodem_rx_ctrl;
  localparam int ADDR_W = 20;
  localparam int TMO    = 1000;

  logic              clk = 1'b0;
  logic              rst_b = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic [7:0]        err_cnt;

  xmodem_rx_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_b(rst_b), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; int cyc; } tx_rec_t;
  typedef struct { logic [ADDR_W-1:0] a; logic [7:0] d; int cyc; } wr_rec_t;
  tx_rec_t txq[$];
  wr_rec_t wq[$];
  logic    txv_prev = 1'b0;

  // Record each new tx byte offer and every memory write, away from the clock edge.
  always @(negedge clk) begin
    if (!rst_b) begin
      txv_prev = 1'b0;
    end else begin
      if (tx_valid && !txv_prev) txq.push_back('{tx_data, cyc});
      txv_prev = tx_valid;
      if (wr_en) wq.push_back('{wr_addr, wr_data, cyc});
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] pkt_data [128];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic gen_data();
    for (int i = 0; i < 128; i++) pkt_data[i] = 8'($urandom);
  endtask

  function automatic logic [7:0] pkt_sum();
    logic [7:0] s = '0;
    for (int i = 0; i < 128; i++) s = s + pkt_data[i];
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, output int c);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1; c = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_head(input logic [7:0] blk, input logic [7:0] blkn);
    int c;
    send_byte(8'h01, c);
    send_byte(blk, c);
    send_byte(blkn, c);
  endtask

  task automatic send_data(input int lo, input int hi, output int last);
    last = 0;
    for (int i = lo; i < hi; i++) send_byte(pkt_data[i], last);
  endtask

  task automatic send_csum(input logic [7:0] delta, output int sc);
    send_byte(pkt_sum() + delta, sc);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_resp(input int lim, output logic [7:0] d, output int c);
    int i = 0;
    while (txq.size() == 0 && i < lim) begin
      @(posedge clk); #1;
      i++;
    end
    if (txq.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL resp_timeout: actual none required a tx byte within %0d cycles", lim);
      d = 8'h00;
      c = 0;
    end else begin
      tx_rec_t r = txq.pop_front();
      d = r.d;
      c = r.cyc;
    end
  endtask

  // Response byte, response latency, write count, and write address/data/timing.
  task automatic check_result(input string tag, input logic [7:0] resp,
                              input int nwr, input int base, input int sc);
    logic [7:0] rd;
    int         rc;
    bit         ok;
    wait_resp(300, rd, rc);
    chk({tag, "_resp"}, rd, resp);
    chk({tag, "_lat"}, rc - sc, (nwr != 0) ? 130 : 2);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_nwr"}, wq.size(), nwr);
    if (nwr != 0 && wq.size() == nwr) begin
      ok = 1'b1;
      for (int i = 0; i < nwr; i++)
        if (wq[i].a != ADDR_W'(base + i) || wq[i].d != pkt_data[i] || wq[i].cyc != sc + 2 + i)
          ok = 1'b0;
      chk({tag, "_wdata"}, ok, 1);
    end
  endtask

  typedef struct {
    logic [7:0] blk;
    logic [7:0] blkn;
    logic [7:0] cdelta;
    logic [7:0] resp;
    int         nwr;
    int         base;
    int         err;
  } vec_t;

  vec_t vec [8];

  initial begin
    int         sc, c, m, rc;
    logic [7:0] rd;

    vec[0] = '{8'h01, 8'hFE, 8'hFF, 8'h15,   0,   0, 1}; // checksum = sum-1
    vec[1] = '{8'h01, 8'hFE, 8'h00, 8'h06, 128,   0, 1}; // block 1 good
    vec[2] = '{8'h01, 8'hFE, 8'h00, 8'h06,   0,   0, 1}; // duplicate block 1
    vec[3] = '{8'h02, 8'hFD, 8'h00, 8'h06, 128, 128, 1}; // block 2 good
    vec[4] = '{8'h03, 8'h03, 8'h00, 8'h15,   0,   0, 2}; // blkn not complemented
    vec[5] = '{8'h04, 8'hFB, 8'h00, 8'h15,   0,   0, 3}; // block 4 while 3 expected
    vec[6] = '{8'h02, 8'hFD, 8'h00, 8'h06,   0,   0, 3}; // duplicate block 2
    vec[7] = '{8'h03, 8'hFC, 8'h00, 8'h06, 128, 256, 3}; // block 3 good

    #1 rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_b = 1'b1;

    // Start solicits with a NAK that is not counted as an error.
    txq.delete();
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_tx_valid", tx_valid, 1);
    chk("start_tx_data", tx_data, 8'h15);
    wait_resp(10, rd, rc);
    chk("start_nak", rd, 8'h15);
    @(posedge clk); #1;
    chk("start_err_cnt", err_cnt, 0);

    txq.delete();
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    chk("start_while_busy", txq.size(), 0);

    for (int v = 0; v < 8; v++) begin
      txq.delete();
      wq.delete();
      gen_data();
      send_head(vec[v].blk, vec[v].blkn);
      send_data(0, 128, c);
      send_csum(vec[v].cdelta, sc);
      check_result($sformatf("v%0d", v), vec[v].resp, vec[v].nwr, vec[v].base, sc);
      chk($sformatf("v%0d_err_cnt", v), err_cnt, vec[v].err);
    end

    // Reset in the middle of DATA.
    gen_data();
    send_head(8'h01, 8'hFE);
    send_data(0, 50, c);
    @(posedge clk); #2;
    rst_b = 1'b0;
    #1;
    chk("mrst_tx_valid", tx_valid, 0);
    chk("mrst_tx_data", tx_data, 0);
    chk("mrst_wr_en", wr_en, 0);
    chk("mrst_wr_addr", wr_addr, 0);
    chk("mrst_wr_data", wr_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    txq.delete();
    wq.delete();
    send_byte(8'h01, c);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_idle_drop", txq.size(), 0);
    chk("mrst_idle_busy", busy, 0);

    // Fresh transfer after reset: block 1 lands at address 0.
    pulse_start();
    wait_resp(10, rd, rc);
    chk("rs_nak", rd, 8'h15);
    wq.delete();
    gen_data();
    send_head(8'h01, 8'hFE);
    send_data(0, 128, c);
    send_csum(8'h00, sc);
    check_result("rs_blk1", 8'h06, 128, 0, sc);
    chk("rs_err_cnt", err_cnt, 0);

    // EOT with the transmitter holding off: tx must stay offered.
    txq.delete();
    tx_ready = 1'b0;
    send_byte(8'h04, c);
    repeat (10) @(posedge clk);
    #1;
    chk("eot_hold_valid", tx_valid, 1);
    chk("eot_hold_data", tx_data, 8'h06);
    chk("eot_hold_done", done, 0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("eot_done", done, 1);
    chk("eot_busy", busy, 0);
    chk("eot_tx_valid", tx_valid, 0);
    chk("eot_one_offer", txq.size(), 1);

    txq.delete();
    send_byte(8'h01, c);
    repeat (3) @(posedge clk);
    #1;
    chk("eot_idle_drop", txq.size(), 0);
    chk("eot_done_sticky", done, 1);

    pulse_start();
    chk("re_done_clr", done, 0);
    chk("re_busy", busy, 1);
    wait_resp(10, rd, rc);
    chk("re_nak", rd, 8'h15);

    // Sender goes quiet after 50 data bytes.
    txq.delete();
    wq.delete();
    gen_data();
    send_head(8'h01, 8'hFE);
    send_data(0, 50, m);
`ifdef XMODEM_TIMEOUT_EN
    wait_resp(1200, rd, rc);
    chk("tmo_nak", rd, 8'h15);
    chk("tmo_lat_in_range", (rc - m >= 1000 && rc - m <= 1002), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("tmo_err_cnt", err_cnt, 1);
    chk("tmo_no_writes", wq.size(), 0);
    txq.delete();
    wq.delete();
    gen_data();
    send_head(8'h01, 8'hFE);
    send_data(0, 128, c);
    send_csum(8'h00, sc);
    check_result("tmo_blk1", 8'h06, 128, 0, sc);
`else
    repeat (TMO + 100) @(posedge clk);
    #1;
    chk("notmo_quiet", txq.size(), 0);
    send_data(50, 128, c);
    send_csum(8'h00, sc);
    check_result("notmo_blk1", 8'h06, 128, 0, sc);
    chk("notmo_err_cnt", err_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: actual simulation still running required finish before 2 ms");
    $fatal(1);
  end

endmodule
